// File: rtl/adder_stream_pkg.sv
// Shared types and defaults for the adder stream controller.
// WIDTH/ADDER_LATENCY defaults must match the external pipelined adder.
package adder_stream_pkg;

    localparam int unsigned DEFAULT_WIDTH         = 8;
    localparam int unsigned DEFAULT_ADDER_LATENCY = 2;

    typedef struct packed {
        logic                     cout;
        logic [DEFAULT_WIDTH-1:0] sum;
    } result_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
        logic                     cin;
    } operand_t;

endpackage

// File: rtl/adder_stream_ctrl_result_fifo.sv
// result_fifo: synchronous FIFO holding adder results until the consumer
// accepts them.
//   clk/reset   : clock, synchronous active-high reset
//   push/wdata  : write one result (never while full)
//   pop/rdata   : rdata is the head entry; pop removes it
//   full/empty  : status flags
//   count       : number of stored entries, 0..DEPTH
module result_fifo
    import adder_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  result_t                wdata,
    input  logic                   pop,
    output result_t                rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned   PW         = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);

    result_t       mem_q [DEPTH];
    result_t       mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/adder_stream_ctrl.sv
// adder_stream_ctrl: valid/ready wrapper around an external pipelined adder.
// Operands are issued to the adder, tracked through its fixed latency by a
// valid shift register, and the results are buffered in a FIFO for the
// downstream consumer. A credit counter (occupancy) reserves a FIFO slot for
// every in-flight operation so the adder never needs back-pressure.
//   in_valid/in_ready, in_a/in_b/in_cin  : upstream operand stream
//   adder_a/adder_b/adder_cin            : to the adder (zero when idle)
//   adder_sum/adder_cout                 : from the adder
//   out_valid/out_ready, out_sum/out_cout: downstream result stream
//   occupancy                            : buffered + in-flight operations
module adder_stream_ctrl
    import adder_stream_pkg::*;
#(
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned ADDER_LATENCY = DEFAULT_ADDER_LATENCY,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_cin,
    output logic [WIDTH-1:0]       adder_a,
    output logic [WIDTH-1:0]       adder_b,
    output logic                   adder_cin,
    input  logic [WIDTH-1:0]       adder_sum,
    input  logic                   adder_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_sum,
    output logic                   out_cout,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic                     fire_in;
    logic                     fire_out;
    logic [ADDER_LATENCY-1:0] vld_q, vld_d;
    logic [CW-1:0]            occ_q, occ_d;
    operand_t                 op_in;
    operand_t                 op_issue;
    result_t                  fifo_wdata;
    result_t                  fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;

    assign in_ready  = (occ_q < DEPTH_C);
    assign fire_in   = in_valid & in_ready;
    assign out_valid = ~fifo_empty;
    assign fire_out  = out_valid & out_ready;

    // Idle cycles drive zeros so the adder datapath does not toggle.
    always_comb begin
        op_in    = '{a: in_a, b: in_b, cin: in_cin};
        op_issue = fire_in ? op_in : '0;
    end

    assign adder_a   = op_issue.a;
    assign adder_b   = op_issue.b;
    assign adder_cin = op_issue.cin;

    always_comb begin
        vld_d[0] = fire_in;
        for (int unsigned k = 1; k < ADDER_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (fire_in && !fire_out) begin
            occ_d = occ_q + ONE_C;
        end else if (!fire_in && fire_out) begin
            occ_d = occ_q - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
        end
    end

    assign fifo_wdata = '{cout: adder_cout, sum: adder_sum};

    result_fifo #(
        .DEPTH(DEPTH)
    ) u_result_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (vld_q[ADDER_LATENCY-1]),
        .wdata (fifo_wdata),
        .pop   (fire_out),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_sum   = fifo_empty ? '0 : fifo_head.sum;
    assign out_cout  = fifo_empty ? 1'b0 : fifo_head.cout;
    assign occupancy = occ_q;

    // The explicit credit register must equal buffered plus in-flight work.
    a_occ_consistent: assert property (@(posedge clk) disable iff (reset)
        occ_q == fifo_count + CW'($countones(vld_q)));
    a_full_blocks_issue: assert property (@(posedge clk) disable iff (reset)
        fifo_full |-> !in_ready);

endmodule

// File: tb/tb_adder_stream_ctrl.sv
module tb_adder_stream_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_a      = '0;
    logic [WIDTH-1:0] in_b      = '0;
    logic             in_cin    = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_b;
    logic             adder_cin;
    logic [WIDTH-1:0] adder_sum;
    logic             adder_cout;
    logic             out_valid;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic [2:0]       occupancy;

    always #5 clk = ~clk;

    adder_stream_ctrl #(
        .WIDTH(WIDTH),
        .ADDER_LATENCY(LAT),
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .occupancy  (occupancy)
    );

    // Behavioural stand-in for the external pipelined adder.
    logic [WIDTH:0] stage [LAT];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= {1'b0, adder_a} + {1'b0, adder_b} + {{WIDTH{1'b0}}, adder_cin};
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end
    assign {adder_cout, adder_sum} = stage[LAT-1];

    int unsigned cyc = 0;
    bit          armed = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) armed <= 1'b1;
    end

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n_issued = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: every accepted operation is a queue entry holding its
    // arithmetic result and issue cycle. Credits in use = entries not yet
    // consumed; a result becomes visible LAT+1 cycles after issue.
    typedef struct {
        logic [WIDTH:0] res;
        int unsigned    cyc;
    } exp_t;
    exp_t exp_q[$];

    bit   m_rdy, m_ov, m_fire;
    exp_t m_new;

    always @(negedge clk) begin
        if (armed) begin
            m_rdy  = exp_q.size() < DEPTH;
            m_ov   = 1'b0;
            if (exp_q.size() != 0) m_ov = (exp_q[0].cyc + LAT + 1 <= cyc);
            m_fire = in_valid && m_rdy;

            check("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
            check("occupancy", {29'd0, occupancy}, exp_q.size());
            check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            check("adder_a", {24'd0, adder_a}, m_fire ? {24'd0, in_a} : 32'd0);
            check("adder_b", {24'd0, adder_b}, m_fire ? {24'd0, in_b} : 32'd0);
            check("adder_cin", {31'd0, adder_cin}, m_fire ? {31'd0, in_cin} : 32'd0);

            if (m_ov) begin
                check("out_sum", {24'd0, out_sum}, {24'd0, exp_q[0].res[WIDTH-1:0]});
                check("out_cout", {31'd0, out_cout}, {31'd0, exp_q[0].res[WIDTH]});
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                check("out_sum_idle", {24'd0, out_sum}, 32'd0);
                check("out_cout_idle", {31'd0, out_cout}, 32'd0);
            end

            if (m_fire) begin
                m_new.res = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
                m_new.cyc = cyc;
                exp_q.push_back(m_new);
                n_issued++;
            end

            if (reset) exp_q.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int unsigned base;

    initial begin
        repeat (2) step();
        reset = 1'b0;
        step();

        // Single op with carry wrap: FF + 01 + 1.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = 8'hFF; in_b = 8'h01; in_cin = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (6) step();

        // Back-to-back stream.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_a   = 8'(i);
            in_b   = 8'(2 * i);
            in_cin = 1'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();

        // Back-pressure until credits run out, then drain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();

        // Simultaneous push and pop with two entries buffered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        in_valid = 1'b1;
        in_a = 8'h80; in_b = 8'h80; in_cin = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        repeat (6) step();

        // Reset with two buffered and two in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        // Randomized traffic.
        base = n_issued;
        for (int c = 0; c < 40000 && (n_issued - base) < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_cin    = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        check("random_issue_budget", {31'd0, (n_issued - base) >= 10000}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
